// File: rtl/fma_queue_pkg.sv
// Shared constants and types for the FMA operand queue: MMIO offsets, status/control
// bit positions and the packed operand triple.
package fma_queue_pkg;

   localparam logic [4:0] OFS_A      = 5'h00;
   localparam logic [4:0] OFS_B      = 5'h04;
   localparam logic [4:0] OFS_C      = 5'h08;
   localparam logic [4:0] OFS_STATUS = 5'h0C;
   localparam logic [4:0] OFS_CTRL   = 5'h10;
   localparam logic [4:0] OFS_ISSUED = 5'h14;

   localparam int unsigned STATUS_EMPTY_BIT = 16;
   localparam int unsigned STATUS_FULL_BIT  = 17;
   localparam int unsigned STATUS_OVF_BIT   = 18;

   localparam int unsigned CTRL_FLUSH_BIT   = 0;
   localparam int unsigned CTRL_CLR_OVF_BIT = 1;

   localparam int unsigned TRIPLE_XLEN = 32;

   typedef struct packed {
      logic [TRIPLE_XLEN-1:0] a;
      logic [TRIPLE_XLEN-1:0] b;
      logic [TRIPLE_XLEN-1:0] c;
   } triple_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, natural-wrap pointers and an explicit
// occupancy counter. Flush has priority over push and pop.
module sync_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
         else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fma_operand_queue.sv
// MMIO front end that stages operand triples from the CPU and streams them to the
// FMA stage through a FIFO, with occupancy, overflow and issue-count status.
module fma_operand_queue
   import fma_queue_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] BASE_ADDR = 32'hC4201000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            en_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] data_i,
   output logic            ready_o,
   output logic [XLEN-1:0] data_o,
   output logic            m_valid_o,
   input  logic            m_ready_i,
   output logic [XLEN-1:0] m_a_o,
   output logic [XLEN-1:0] m_b_o,
   output logic [XLEN-1:0] m_c_o,
   output logic            irq_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            ready_q;
   logic [XLEN-1:0] data_q, data_d;
   logic [XLEN-1:0] a_q, b_q;
   logic            ovf_q;
   logic            drained_q;
   logic [CNT_W-1:0] issued_q;

   logic [3*XLEN-1:0] fifo_din, fifo_dout;
   logic              fifo_empty, fifo_full;
   logic [CW-1:0]     fifo_count;

   logic       hit;
   logic [4:0] ofs;
   logic       wr_a, wr_b, wr_c, wr_ctrl, rd_acc;
   logic       flush, clr_ovf, pop_req, pop_fire, ovf_push;
   logic [XLEN-1:0] status_word;

   assign hit     = en_i && (addr_i[31:5] == BASE_ADDR[31:5]);
   assign ofs     = addr_i[4:0];
   assign wr_a    = hit && we_i && (ofs == OFS_A);
   assign wr_b    = hit && we_i && (ofs == OFS_B);
   assign wr_c    = hit && we_i && (ofs == OFS_C);
   assign wr_ctrl = hit && we_i && (ofs == OFS_CTRL);
   assign rd_acc  = hit && !we_i;

   assign flush   = wr_ctrl && data_i[CTRL_FLUSH_BIT];
   assign clr_ovf = wr_ctrl && data_i[CTRL_CLR_OVF_BIT];

   // Valid is purely registered state; ready only feeds the pop decision.
   assign pop_req  = !fifo_empty && m_ready_i;
   assign pop_fire = pop_req && !flush;
   assign ovf_push = wr_c && fifo_full && !pop_fire;

   assign fifo_din = {a_q, b_q, data_i};

   sync_fifo #(
      .WIDTH (3*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (wr_c),
      .pop    (pop_req),
      .flush  (flush),
      .din    (fifo_din),
      .dout   (fifo_dout),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .count  (fifo_count)
   );

   always_comb begin
      status_word = '0;
      status_word[CW-1:0]           = fifo_count;
      status_word[STATUS_EMPTY_BIT] = fifo_empty;
      status_word[STATUS_FULL_BIT]  = fifo_full;
      status_word[STATUS_OVF_BIT]   = ovf_q;
   end

   always_comb begin
      data_d = '0;
      if (rd_acc) begin
         case (ofs)
            OFS_STATUS: data_d = status_word;
            OFS_ISSUED: data_d[CNT_W-1:0] = issued_q;
            default:    data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ready_q   <= 1'b0;
         data_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         ovf_q     <= 1'b0;
         drained_q <= 1'b0;
         issued_q  <= '0;
      end else begin
         ready_q <= en_i;
         data_q  <= data_d;
         if (wr_a) a_q <= data_i;
         if (wr_b) b_q <= data_i;
         // An overflowing push outranks a same-cycle clear.
         if (ovf_push)     ovf_q <= 1'b1;
         else if (clr_ovf) ovf_q <= 1'b0;
         if (pop_fire) issued_q <= issued_q + CNT_W'(1);
         if (wr_c || flush) drained_q <= 1'b0;
         else if (pop_fire && (fifo_count == CW'(1))) drained_q <= 1'b1;
      end
   end

   assign ready_o   = ready_q;
   assign data_o    = data_q;
   assign m_valid_o = !fifo_empty;
   assign m_a_o     = fifo_dout[3*XLEN-1:2*XLEN];
   assign m_b_o     = fifo_dout[2*XLEN-1:XLEN];
   assign m_c_o     = fifo_dout[XLEN-1:0];
   assign irq_o     = fifo_empty && drained_q;

endmodule

// File: tb/tb_fma_operand_queue.sv
// Directed bench for fma_operand_queue: register readback, push/pop, overflow,
// full-FIFO push with pop, back-pressure stability, flush and asynchronous reset.
module tb_fma_operand_queue;
   import fma_queue_pkg::*;

   localparam logic [31:0] BASE = 32'hC4201000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        en_i, we_i, m_ready_i;
   logic [31:0] addr_i, data_i;
   logic        ready_o, m_valid_o, irq_o;
   logic [31:0] data_o, m_a_o, m_b_o, m_c_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic        mon_en = 1'b0;
   logic        mon_v, mon_r;
   logic [31:0] mon_h;
   logic        bp_stop;
   logic [31:0] rd;

   fma_operand_queue #(
      .XLEN      (32),
      .DEPTH     (8),
      .BASE_ADDR (BASE),
      .CNT_W     (16)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .ready_o   (ready_o),
      .data_o    (data_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .m_a_o     (m_a_o),
      .m_b_o     (m_b_o),
      .m_c_o     (m_c_o),
      .irq_o     (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata);
      @(negedge clk_i);
      en_i = 1'b1; we_i = we; addr_i = addr; data_i = wdata;
      @(negedge clk_i);
      en_i = 1'b0; we_i = 1'b0;
      rdata = data_o;
      check_eq("ready_pulse", ready_o, 1);
   endtask

   task automatic bus_wr(input logic [4:0] ofs, input logic [31:0] wdata);
      logic [31:0] dummy;
      bus_access(1'b1, BASE + 32'(ofs), wdata, dummy);
   endtask

   task automatic bus_rd(input logic [4:0] ofs, output logic [31:0] rdata);
      bus_access(1'b0, BASE + 32'(ofs), 32'h0, rdata);
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp_c);
      @(negedge clk_i);
      check_eq({tag, "_valid"}, m_valid_o, 1);
      check_eq({tag, "_c"}, m_c_o, exp_c);
      m_ready_i = 1'b1;
      @(negedge clk_i);
      m_ready_i = 1'b0;
   endtask

   // Stream monitor: pops must match the scoreboard, stalls must hold the head.
   always @(posedge clk_i) begin
      if (mon_en) begin
         mon_v = m_valid_o;
         mon_r = m_ready_i;
         mon_h = m_c_o;
         #1;
         if (mon_v && mon_r) begin
            check_eq("bp_pop_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("bp_pop_data", mon_h, exp_q.pop_front());
         end else if (mon_v) begin
            check_eq("bp_stall_valid", m_valid_o, 1);
            check_eq("bp_stall_data", m_c_o, mon_h);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      en_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; m_ready_i = 1'b0;
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      #2;
      check_eq("rst_ready", ready_o, 0);
      check_eq("rst_data", data_o, 0);
      check_eq("rst_valid", m_valid_o, 0);
      check_eq("rst_irq", irq_o, 0);
      #9 rst_ni = 1'b1;

      bus_rd(OFS_STATUS, rd); check_eq("status_reset", rd, 32'h0001_0000);
      bus_rd(OFS_ISSUED, rd); check_eq("issued_reset", rd, 0);

      // Single push then pop
      bus_wr(OFS_A, 32'h3F80_0000);
      bus_wr(OFS_B, 32'h4000_0000);
      bus_wr(OFS_C, 32'h4040_0000);
      check_eq("single_valid", m_valid_o, 1);
      check_eq("single_a", m_a_o, 32'h3F80_0000);
      check_eq("single_b", m_b_o, 32'h4000_0000);
      check_eq("single_c", m_c_o, 32'h4040_0000);
      check_eq("single_irq_pre", irq_o, 0);
      bus_rd(OFS_STATUS, rd); check_eq("single_status", rd, 32'h0000_0001);
      @(negedge clk_i); m_ready_i = 1'b1;
      @(negedge clk_i); m_ready_i = 1'b0;
      check_eq("single_valid_after", m_valid_o, 0);
      check_eq("single_irq", irq_o, 1);
      bus_rd(OFS_ISSUED, rd); check_eq("single_issued", rd, 1);

      // Unmapped / wrong-direction accesses
      bus_rd(OFS_A, rd); check_eq("rd_write_only", rd, 0);
      bus_access(1'b1, 32'hC420_2000 + 32'(OFS_C), 32'h55, rd);
      bus_wr(OFS_STATUS, 32'hFFFF_FFFF);
      bus_rd(5'h18, rd); check_eq("rd_unmapped", rd, 0);
      bus_rd(OFS_STATUS, rd); check_eq("status_unchanged", rd, 32'h0001_0000);

      // Fill past capacity, staged A/B reused
      for (int i = 1; i <= 9; i++) bus_wr(OFS_C, 32'(i));
      bus_rd(OFS_STATUS, rd); check_eq("ovf_status", rd, 32'h0006_0008);
      check_eq("reuse_a", m_a_o, 32'h3F80_0000);
      check_eq("reuse_b", m_b_o, 32'h4000_0000);
      for (int i = 1; i <= 8; i++) pop_check("drain", 32'(i));
      @(negedge clk_i);
      check_eq("drain_empty", m_valid_o, 0);
      check_eq("drain_irq", irq_o, 1);
      bus_rd(OFS_ISSUED, rd); check_eq("drain_issued", rd, 9);
      bus_wr(OFS_CTRL, 32'h2);
      bus_rd(OFS_STATUS, rd); check_eq("ovf_cleared", rd, 32'h0001_0000);

      // Push into a full FIFO while the head pops
      for (int i = 0; i < 8; i++) bus_wr(OFS_C, 32'h11 + 32'(i));
      @(negedge clk_i);
      en_i = 1'b1; we_i = 1'b1; addr_i = BASE + 32'(OFS_C); data_i = 32'hA; m_ready_i = 1'b1;
      @(negedge clk_i);
      en_i = 1'b0; we_i = 1'b0; m_ready_i = 1'b0;
      check_eq("fullpop_ready", ready_o, 1);
      bus_rd(OFS_STATUS, rd); check_eq("fullpop_status", rd, 32'h0002_0008);
      for (int i = 1; i < 8; i++) pop_check("fullpop", 32'h11 + 32'(i));
      pop_check("fullpop_last", 32'hA);
      bus_rd(OFS_ISSUED, rd); check_eq("fullpop_issued", rd, 18);

      // Back-pressure with a fixed ready pattern
      bp_stop = 1'b0;
      mon_en  = 1'b1;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               exp_q.push_back(32'h100 + 32'(i));
               bus_wr(OFS_C, 32'h100 + 32'(i));
            end
            for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk_i);
            check_eq("bp_drained", exp_q.size(), 0);
            bp_stop = 1'b1;
         end
         begin
            logic [7:0] pat;
            pat = 8'b1101_0110;
            for (int k = 0; !bp_stop; k++) begin
               @(negedge clk_i);
               m_ready_i = pat[k % 8];
            end
            m_ready_i = 1'b0;
         end
      join
      @(negedge clk_i);
      mon_en = 1'b0;
      bus_rd(OFS_ISSUED, rd); check_eq("bp_issued", rd, 38);
      bus_rd(OFS_STATUS, rd); check_eq("bp_status", rd, 32'h0001_0000);

      // Flush
      for (int i = 0; i < 3; i++) bus_wr(OFS_C, 32'h21 + 32'(i));
      bus_rd(OFS_STATUS, rd); check_eq("flush_pre_status", rd, 32'h0000_0003);
      bus_wr(OFS_CTRL, 32'h1);
      check_eq("flush_valid", m_valid_o, 0);
      check_eq("flush_irq", irq_o, 0);
      bus_rd(OFS_STATUS, rd); check_eq("flush_status", rd, 32'h0001_0000);
      bus_rd(OFS_ISSUED, rd); check_eq("flush_issued", rd, 38);

      // Asynchronous reset between clock edges
      bus_wr(OFS_C, 32'h31);
      bus_wr(OFS_C, 32'h32);
      check_eq("prerst_valid", m_valid_o, 1);
      check_eq("prerst_ready", ready_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      check_eq("arst_ready", ready_o, 0);
      check_eq("arst_data", data_o, 0);
      check_eq("arst_valid", m_valid_o, 0);
      check_eq("arst_irq", irq_o, 0);
      #10 rst_ni = 1'b1;
      bus_rd(OFS_STATUS, rd); check_eq("arst_status", rd, 32'h0001_0000);
      bus_rd(OFS_ISSUED, rd); check_eq("arst_issued", rd, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
